// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM generator with per-motor dead-time insertion.
// Ports:
//   clk                  system clock, all state on rising edge
//   rst_n                asynchronous active-low reset
//   lft_spd, rght_spd    signed 12-bit speed commands
//   PWM1_*/PWM2_*        high-side / low-side bridge drives per motor
//   PWM_synch            one-cycle pulse on the last cycle of each 2048-cycle period
module mtr_drv #(
    parameter logic [5:0] NONOVERLAP = 6'd32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic        PWM1_lft,
    output logic        PWM2_lft,
    output logic        PWM1_rght,
    output logic        PWM2_rght,
    output logic        PWM_synch
);
    typedef enum logic [1:0] {DEAD, HI, LO} state_t;

    logic [10:0] cnt_q;
    logic        synch_q;
    logic        wrap;
    logic [1:0]  pwm1, pwm2;

    // Clipped speed offset by +1024; for -1024..1023 that is just bit 10 inverted.
    function automatic logic [10:0] duty_of(input logic [11:0] spd);
        return ($signed(spd) < -12'sd1024) ? 11'h000 :
               ($signed(spd) >  12'sd1023) ? 11'h7ff : {~spd[10], spd[9:0]};
    endfunction

    assign wrap = cnt_q == 11'h7ff;

    // Synch is registered one cycle early so it lines up with cnt_q==0x7FF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            synch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 11'd1;
            synch_q <= cnt_q == 11'h7fe;
        end
    end

    for (genvar m = 0; m < 2; m++) begin : g_mtr
        logic [10:0] duty_q;
        logic        raw_q, rawp_q, chg;
        state_t      st_q, st_d;
        logic [5:0]  dead_q, dead_d;
        logic        pwm1_q, pwm2_q;

        assign chg = raw_q ^ rawp_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_q <= 11'h400;
                raw_q  <= 1'b0;
                rawp_q <= 1'b0;
                st_q   <= DEAD;
                dead_q <= '0;
                pwm1_q <= 1'b0;
                pwm2_q <= 1'b0;
            end else begin
                if (wrap) duty_q <= duty_of((m == 0) ? lft_spd : rght_spd);
                raw_q  <= cnt_q < duty_q;
                rawp_q <= raw_q;
                st_q   <= st_d;
                dead_q <= dead_d;
                // Outputs decoded from the next state so they are true flops.
                pwm1_q <= st_d == HI;
                pwm2_q <= st_d == LO;
            end
        end

        // A raw edge always (re)starts the dead-time; only a full quiet
        // dead-time lets a side turn on.
        always_comb begin
            st_d   = (st_q != DEAD) ? (chg ? DEAD : st_q) :
                     (!chg && dead_q == NONOVERLAP - 6'd1) ? (raw_q ? HI : LO) : DEAD;
            dead_d = (st_q == DEAD && !chg && dead_q != NONOVERLAP - 6'd1) ? dead_q + 6'd1 : '0;
        end

        assign pwm1[m] = pwm1_q;
        assign pwm2[m] = pwm2_q;
    end

    assign PWM1_lft  = pwm1[0];
    assign PWM2_lft  = pwm2[0];
    assign PWM1_rght = pwm1[1];
    assign PWM2_rght = pwm2[1];
    assign PWM_synch = synch_q;
endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: randomized self-checking bench for mtr_drv against a raw-history reference model.
module tb_mtr_drv;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_spd = '0, rght_spd = '0;
    logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch;

    int n_cmp = 0, n_err = 0;

    int m_cnt = 0;
    int m_sh[2] = '{1024, 1024};
    bit hist_l[$], hist_r[$];

    mtr_drv #(.NONOVERLAP(6'd32)) dut (
        .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .PWM1_lft(PWM1_lft), .PWM2_lft(PWM2_lft),
        .PWM1_rght(PWM1_rght), .PWM2_rght(PWM2_rght), .PWM_synch(PWM_synch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int duty(input logic [11:0] spd);
        int s, c;
        s = $signed(spd);
        c = (s < -1024) ? -1024 : (s > 1023) ? 1023 : s;
        return c + 1024;
    endfunction

    // A side is on iff the raw signal held value v over the N+1 cycles before
    // the current one (pre-reset history never counts).
    function automatic bit win(input bit q[$], input bit v);
        if (q.size() < N + 2) return 1'b0;
        for (int i = q.size() - N - 2; i <= q.size() - 2; i++)
            if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_sh   = '{1024, 1024};
            hist_l = {1'b0};
            hist_r = {1'b0};
        end else begin
            hist_l.push_back(m_cnt < m_sh[0]);
            hist_r.push_back(m_cnt < m_sh[1]);
            if (hist_l.size() > N + 3) void'(hist_l.pop_front());
            if (hist_r.size() > N + 3) void'(hist_r.pop_front());
            if (m_cnt == 2047) m_sh = '{duty(lft_spd), duty(rght_spd)};
            m_cnt = (m_cnt + 1) % 2048;
        end
    end

    always @(negedge clk) begin
        chk("synch", PWM_synch, m_cnt == 2047);
        chk("pwm1_l", PWM1_lft, win(hist_l, 1'b1));
        chk("pwm2_l", PWM2_lft, win(hist_l, 1'b0));
        chk("pwm1_r", PWM1_rght, win(hist_r, 1'b1));
        chk("pwm2_r", PWM2_rght, win(hist_r, 1'b0));
        chk("ovl_l", PWM1_lft & PWM2_lft, 0);
        chk("ovl_r", PWM1_rght & PWM2_rght, 0);
    end

    task automatic wait_cnt(input int v);
        int k = 0;
        while (m_cnt != v && k < 5000) begin @(negedge clk); k++; end
        chk("cnt_timeout", k < 5000, 1);
    endtask

    task automatic measure(output int p1l, output int p2l, output int p1r, output int p2r);
        int k = 0;
        p1l = 0; p2l = 0; p1r = 0; p2r = 0;
        while (PWM_synch !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
        chk("synch_timeout", k < 5000, 1);
        repeat (2048) begin
            @(negedge clk);
            p1l += int'(PWM1_lft); p2l += int'(PWM2_lft);
            p1r += int'(PWM1_rght); p2r += int'(PWM2_rght);
        end
    endtask

    initial begin
        int p1l, p2l, p1r, p2r, quiet;
        logic [11:0] picks[8];
        picks = '{12'd0, 12'd1023, 12'hc00, 12'd1024, 12'hbff, 12'h7ff, 12'h800, 12'd1};
        rght_spd = 12'hc00;
        repeat (4) @(negedge clk);
        chk("rst_p1l", PWM1_lft, 0);
        chk("rst_p2l", PWM2_lft, 0);
        chk("rst_synch", PWM_synch, 0);
        rst_n = 1'b1;
        repeat (2 * 2048) @(negedge clk);
        measure(p1l, p2l, p1r, p2r);
        chk("zero_p1l", p1l, 992);
        chk("zero_p2l", p2l, 992);
        chk("neg_p1r", p1r, 0);
        chk("neg_p2r", p2r, 2048);
        lft_spd = 12'd1023;
        repeat (2200) @(negedge clk);
        measure(p1l, p2l, p1r, p2r);
        chk("max_p1l", p1l, 2015);
        chk("max_p2l", p2l, 0);
        lft_spd = 12'd1500;
        repeat (2200) @(negedge clk);
        measure(p1l, p2l, p1r, p2r);
        chk("clip_hi_p1l", p1l, 2015);
        chk("clip_hi_p2l", p2l, 0);
        lft_spd = 12'h800;
        repeat (2200) @(negedge clk);
        measure(p1l, p2l, p1r, p2r);
        chk("clip_lo_p1l", p1l, 0);
        chk("clip_lo_p2l", p2l, 2048);
        lft_spd = 12'd0;
        repeat (2200) @(negedge clk);
        wait_cnt(12'h200);
        lft_spd = 12'd512;
        measure(p1l, p2l, p1r, p2r);
        chk("mid_p1l", p1l, 1504);
        chk("mid_p2l", p2l, 480);
        wait_cnt(12'h300);
        chk("pre_rst_p1l", PWM1_lft, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_p1l", PWM1_lft, 0);
        chk("async_p2l", PWM2_lft, 0);
        chk("async_p1r", PWM1_rght, 0);
        chk("async_p2r", PWM2_rght, 0);
        chk("async_synch", PWM_synch, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (N) begin
            @(negedge clk);
            quiet += int'(PWM1_lft | PWM2_lft | PWM1_rght | PWM2_rght);
        end
        chk("post_rst_quiet", quiet, 0);
        for (int i = 0; i < 12; i++) begin
            lft_spd  = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 7)] : 12'($urandom);
            rght_spd = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 7)] : 12'($urandom);
            repeat ($urandom_range(100, 3000)) @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 The block SHALL have parameter NONOVERLAP, default 6'd32, giving the dead-time in clk cycles between one bridge side switching off and the other switching on (legal 1..63).
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port lft_spd, input, 12 bits, the signed left motor speed command.
REQ-005 The block SHALL have port rght_spd, input, 12 bits, the signed right motor speed command.
REQ-006 The block SHALL have ports PWM1_lft and PWM2_lft, outputs, 1 bit each, the left H-bridge high-side and low-side drives.
REQ-007 The block SHALL have ports PWM1_rght and PWM2_rght, outputs, 1 bit each, the right H-bridge high-side and low-side drives.
REQ-008 The block SHALL have port PWM_synch, output, 1 bit, a one-cycle pulse marking the end of a PWM period.

Function
REQ-009 The block SHALL keep an 11-bit free-running period counter, cnt, that increments every clk and wraps from 0x7FF to 0x000, giving a 2048-cycle period.
REQ-010 For each motor, the block SHALL clip spd to the range -1024..+1023 (values below -1024 become -1024, values above 1023 become 1023) and SHALL then compute duty = clipped + 1024, an unsigned 11-bit value from 0 to 2047.
REQ-011 The block SHALL load each computed duty into its shadow register only on the cycle where cnt==0x7FF, so that a spd change during a period takes effect at the start of the next period.
REQ-012 PWM_synch SHALL be 1 exactly on the cycle where cnt==0x7FF and 0 on all other cycles.
REQ-013 For each motor, the block SHALL register a raw PWM signal, raw = (cnt < shadow duty); duty 0 gives raw always 0, and duty 2047 gives raw 0 only while cnt==0x7FF.
REQ-014 The block SHALL have one independent 3-state non-overlap FSM per motor, with states DEAD, HI and LO.
REQ-015 In DEAD, both drive outputs SHALL be 0 and a 6-bit dead counter SHALL increment.
REQ-016 When the dead counter reaches NONOVERLAP-1 with raw unchanged, the FSM SHALL go to HI if raw==1, or to LO if raw==0.
REQ-017 In HI, PWM1 SHALL be 1 and PWM2 SHALL be 0; in LO, PWM2 SHALL be 1 and PWM1 SHALL be 0.
REQ-018 From HI or LO, any change of raw SHALL move the FSM to DEAD on the next edge with the dead counter cleared, so the active output drops within 1 cycle of the raw change.
REQ-019 A raw change while in DEAD SHALL clear the dead counter, restarting the dead-time.
REQ-020 PWM1 and PWM2 of the same motor SHALL never be 1 on the same cycle, under any input sequence.
REQ-021 Every edge in which a side turns on SHALL be preceded by at least NONOVERLAP consecutive cycles with both of that motor's outputs at 0.
REQ-022 All outputs SHALL be registered, with no combinational path from lft_spd or rght_spd to any output.

Reset
REQ-023 While rst_n==0, the block SHALL set cnt=0, both shadow duties=0x400 (zero torque), both FSMs to DEAD with the dead counter at 0, and all PWM outputs and PWM_synch to 0.
REQ-024 After rst_n deasserts, the block SHALL keep all drive outputs at 0 for at least NONOVERLAP cycles before either side asserts.
REQ-025 An rst_n assertion mid-period SHALL force all outputs to 0 immediately and asynchronously, without waiting for a clock edge.

Verification
REQ-026 Hold lft_spd=0 for 3 periods -> from the 2nd period on, each 2048-cycle period SHALL show PWM1_lft high for 992 cycles and PWM2_lft high for 992 cycles, with 32-cycle gaps at both transitions.
REQ-027 Set lft_spd=+1023 -> PWM1_lft SHALL be high for 2015 cycles per period and PWM2_lft SHALL never assert, because the 1-cycle raw low is shorter than the dead-time.
REQ-028 Set rght_spd=-1024 -> PWM2_rght SHALL be constantly high after the first period, and PWM1_rght SHALL be 0.
REQ-029 Set lft_spd=+1500, then lft_spd=-2048 -> the outputs SHALL be identical to +1023 and -1024 respectively (clip check).
REQ-030 Change lft_spd from 0 to +512 at cnt==0x200 -> the current period SHALL keep duty 0x400, and the next period SHALL use duty 0x600, with PWM_synch pulsing at the boundary.
REQ-031 Assert rst_n=0 at cnt==0x300 while PWM1_lft==1 -> all outputs SHALL go to 0 asynchronously; after release, outputs SHALL stay 0 for at least 32 cycles, and the overlap checker SHALL report no violation throughout.
